// File: rtl/sub_dispatcher_pkg.sv
// Shared types for the sub-core dispatcher: controller state encoding and word width.
package sub_dispatcher_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ARM,
        WAIT,
        ISSUE,
        LAT,
        WRITE,
        DONE
    } disp_state_t;

endpackage

// File: rtl/sub_dispatcher_if.sv
// Bundle of everything the dispatcher exchanges with the main core, the sub cores and main memory.
interface sub_dispatcher_if
    import sub_dispatcher_pkg::*;
#(
    parameter int N_CORES = 4
);
    logic                        start;
    logic [WORD_W-1:0]           start_pc;
    logic [N_CORES-1:0]          core_mask;
    logic [WORD_W-1:0]           gather_base;
    logic [15:0]                 gather_len;
    logic [WORD_W-1:0]           dst_base;
    logic                        busy;
    logic                        done;
    logic [N_CORES-1:0]          exec_requested;
    logic [WORD_W-1:0]           requested_pc;
    logic [N_CORES-1:0]          ended;
    logic [WORD_W-1:0]           fetch_addr;
    logic [WORD_W*N_CORES-1:0]   fetch_result;
    logic                        wr_valid;
    logic [WORD_W-1:0]           wr_addr;
    logic [WORD_W-1:0]           wr_data;
    logic                        wr_ready;

    modport master (
        input  start, start_pc, core_mask, gather_base, gather_len, dst_base,
        input  ended, fetch_result, wr_ready,
        output busy, done, exec_requested, requested_pc, fetch_addr,
        output wr_valid, wr_addr, wr_data
    );

    modport slave (
        output start, start_pc, core_mask, gather_base, gather_len, dst_base,
        output ended, fetch_result, wr_ready,
        input  busy, done, exec_requested, requested_pc, fetch_addr,
        input  wr_valid, wr_addr, wr_data
    );

endinterface

// File: rtl/sub_dispatcher_mask_next_core.sv
// Priority finder: lowest set bit of the core mask at or above index 'from'.
module mask_next_core
    import sub_dispatcher_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int IW      = 2
) (
    input  logic [N_CORES-1:0] mask,
    input  logic [IW:0]        from,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    // Scanning downward lets the lowest qualifying bit overwrite any higher one.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (mask[i] && ((IW + 1)'(i) >= from)) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_dispatcher.sv
// Launches selected sub cores on a shared PC, waits for all to end, then packs a window of each core's memory into main memory.
module sub_dispatcher
    import sub_dispatcher_pkg::*;
#(
    parameter int N_CORES   = 4,
    parameter int FETCH_LAT = 2
) (
    input logic              clk,
    input logic              rst,
    sub_dispatcher_if.master bus
);

    localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int CW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
    localparam logic [CW-1:0] LAT_LAST = CW'(FETCH_LAT - 1);

    disp_state_t        state, state_nxt;
    logic [N_CORES-1:0] mask_q, mask_nxt;
    logic [WORD_W-1:0]  gbase_q, gbase_nxt;
    logic [WORD_W-1:0]  dbase_q, dbase_nxt;
    logic [15:0]        len_q, len_nxt;
    logic [15:0]        k_q, k_nxt;
    logic [IW-1:0]      idx_q, idx_nxt;
    logic [CW-1:0]      lat_q, lat_nxt;
    logic               busy_q, busy_nxt;
    logic               done_q, done_nxt;
    logic [N_CORES-1:0] exec_q, exec_nxt;
    logic [WORD_W-1:0]  rpc_q, rpc_nxt;
    logic [WORD_W-1:0]  faddr_q, faddr_nxt;
    logic               wvalid_q, wvalid_nxt;
    logic [WORD_W-1:0]  waddr_q, waddr_nxt;
    logic [WORD_W-1:0]  wdata_q, wdata_nxt;

    logic [IW:0]        search_from;
    logic [IW-1:0]      found_idx;
    logic               found_valid;
    logic [16:0]        k_inc;
    logic [WORD_W-1:0]  fetch_words [N_CORES];

    for (genvar i = 0; i < N_CORES; i++) begin : g_words
        assign fetch_words[i] = bus.fetch_result[WORD_W*i +: WORD_W];
    end

    assign k_inc = {1'b0, k_q} + 17'd1;

    mask_next_core #(
        .N_CORES(N_CORES),
        .IW     (IW)
    ) u_next_core (
        .mask (mask_q),
        .from (search_from),
        .idx  (found_idx),
        .valid(found_valid)
    );

    // Every output is a register; this block computes the value each one takes at the next edge.
    always_comb begin
        state_nxt   = state;
        mask_nxt    = mask_q;
        gbase_nxt   = gbase_q;
        dbase_nxt   = dbase_q;
        len_nxt     = len_q;
        k_nxt       = k_q;
        idx_nxt     = idx_q;
        lat_nxt     = lat_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        exec_nxt    = '0;
        rpc_nxt     = rpc_q;
        faddr_nxt   = faddr_q;
        wvalid_nxt  = wvalid_q;
        waddr_nxt   = waddr_q;
        wdata_nxt   = wdata_q;
        search_from = '0;

        case (state)
            IDLE: begin
                // done_q is high in the first IDLE cycle; a start there is dropped.
                if (bus.start && !done_q) begin
                    mask_nxt  = bus.core_mask;
                    gbase_nxt = bus.gather_base;
                    dbase_nxt = bus.dst_base;
                    len_nxt   = bus.gather_len;
                    rpc_nxt   = bus.start_pc;
                    busy_nxt  = 1'b1;
                    if (bus.core_mask == '0) begin
                        state_nxt = DONE;
                    end else begin
                        exec_nxt  = bus.core_mask;
                        state_nxt = LAUNCH;
                    end
                end
            end
            LAUNCH: state_nxt = ARM;
            ARM:    state_nxt = WAIT;
            WAIT: begin
                if ((bus.ended & mask_q) == mask_q) begin
                    if (len_q == 16'd0) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = found_idx;
                        k_nxt     = '0;
                        waddr_nxt = dbase_q;
                        faddr_nxt = gbase_q;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                lat_nxt   = '0;
                state_nxt = LAT;
            end
            LAT: begin
                if (lat_q == LAT_LAST) begin
                    wdata_nxt  = fetch_words[idx_q];
                    wvalid_nxt = 1'b1;
                    state_nxt  = WRITE;
                end else begin
                    lat_nxt = lat_q + CW'(1);
                end
            end
            WRITE: begin
                search_from = {1'b0, idx_q} + (IW + 1)'(1);
                if (bus.wr_ready) begin
                    wvalid_nxt = 1'b0;
                    waddr_nxt  = waddr_q + 32'd1;
                    if (k_inc < {1'b0, len_q}) begin
                        k_nxt     = k_inc[15:0];
                        faddr_nxt = gbase_q + 32'(k_inc);
                        state_nxt = ISSUE;
                    end else if (found_valid) begin
                        idx_nxt   = found_idx;
                        k_nxt     = '0;
                        faddr_nxt = gbase_q;
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mask_q   <= '0;
            gbase_q  <= '0;
            dbase_q  <= '0;
            len_q    <= '0;
            k_q      <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exec_q   <= '0;
            rpc_q    <= '0;
            faddr_q  <= '0;
            wvalid_q <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            mask_q   <= mask_nxt;
            gbase_q  <= gbase_nxt;
            dbase_q  <= dbase_nxt;
            len_q    <= len_nxt;
            k_q      <= k_nxt;
            idx_q    <= idx_nxt;
            lat_q    <= lat_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            exec_q   <= exec_nxt;
            rpc_q    <= rpc_nxt;
            faddr_q  <= faddr_nxt;
            wvalid_q <= wvalid_nxt;
            waddr_q  <= waddr_nxt;
            wdata_q  <= wdata_nxt;
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.exec_requested = exec_q;
    assign bus.requested_pc   = rpc_q;
    assign bus.fetch_addr     = faddr_q;
    assign bus.wr_valid       = wvalid_q;
    assign bus.wr_addr        = waddr_q;
    assign bus.wr_data        = wdata_q;

endmodule

// File: tb/tb_sub_dispatcher.sv
// Self-checking bench for sub_dispatcher: directed scenarios plus randomized launches against a write-list reference model.
module tb_sub_dispatcher;
    import sub_dispatcher_pkg::*;

    localparam int N = 4;
    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] salt;
    logic [31:0] pipe [L];

    sub_dispatcher_if #(.N_CORES(N)) bus ();

    sub_dispatcher #(
        .N_CORES  (N),
        .FETCH_LAT(L)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Sub-core memory contents: a fixed scramble of core number and address.
    function automatic logic [31:0] mem_word(input int core, input logic [31:0] addr, input logic [31:0] s);
        return (addr * 32'h9E37_79B1) ^ {core[3:0], 28'h0} ^ s;
    endfunction

    // Sub-core memories answer FETCH_LAT cycles after the address changes.
    always @(posedge clk) begin
        pipe[0] <= bus.fetch_addr;
        for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end

    always_comb begin
        bus.fetch_result = '0;
        for (int i = 0; i < N; i++) bus.fetch_result[32*i +: 32] = mem_word(i, pipe[L-1], salt);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"},  32'(bus.busy), 32'd0);
        check_output({tag, "_done"},  32'(bus.done), 32'd0);
        check_output({tag, "_exec"},  32'(bus.exec_requested), 32'd0);
        check_output({tag, "_rpc"},   bus.requested_pc, 32'd0);
        check_output({tag, "_faddr"}, bus.fetch_addr, 32'd0);
        check_output({tag, "_wvld"},  32'(bus.wr_valid), 32'd0);
        check_output({tag, "_waddr"}, bus.wr_addr, 32'd0);
        check_output({tag, "_wdata"}, bus.wr_data, 32'd0);
    endtask

    task automatic apply_stimulus(input logic [N-1:0] mask, input logic [31:0] pc, input logic [31:0] gbase,
                                  input logic [15:0] len, input logic [31:0] dbase);
        bus.core_mask   = mask;
        bus.start_pc    = pc;
        bus.gather_base = gbase;
        bus.gather_len  = len;
        bus.dst_base    = dbase;
        bus.ended       = '1;
        bus.start       = 1'b1;
    endtask

    // One full operation: start, staggered ended, gather, done. ready_mode 0=always, 1=random, 2=5-cycle stall on first write.
    task automatic run_op(input logic [N-1:0] mask, input logic [31:0] pc, input logic [31:0] gbase,
                          input logic [15:0] len, input logic [31:0] dbase, input int ready_mode,
                          input int restart_cycle, input bit start_at_done);
        logic [31:0] exp_addr [$];
        logic [31:0] exp_data [$];
        int   rise [N];
        int   r_last, nacc, first_valid, done_cycle, stall, w, exp_done;
        bit   done_seen;
        logic rdy;

        w = 0;
        for (int c = 0; c < N; c++) begin
            if (mask[c]) begin
                for (int k = 0; k < int'(len); k++) begin
                    exp_addr.push_back(dbase + 32'(w));
                    exp_data.push_back(mem_word(c, gbase + 32'(k), salt));
                    w++;
                end
            end
        end
        r_last = 3;
        for (int c = 0; c < N; c++) begin
            rise[c] = 3 + int'($urandom_range(0, 6));
            if (mask[c] && rise[c] > r_last) r_last = rise[c];
        end

        apply_stimulus(mask, pc, gbase, len, dbase);
        nacc = 0; first_valid = -1; done_cycle = -1; stall = -1; done_seen = 1'b0;

        for (int n = 1; n <= 3000 && !done_seen; n++) begin
            tick();
            bus.start = (n == restart_cycle);
            if (n == restart_cycle) begin
                bus.core_mask   = ~mask;
                bus.start_pc    = ~pc;
                bus.gather_base = ~gbase;
                bus.gather_len  = len + 16'd3;
                bus.dst_base    = ~dbase;
            end
            for (int c = 0; c < N; c++)
                bus.ended[c] = (n < 3) ? 1'b1 : (mask[c] ? (n >= rise[c]) : 1'($urandom_range(0, 1)));
            case (ready_mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.wr_valid && stall < 0) stall = 5;
                    rdy = !(stall > 0);
                    if (stall > 0) stall--;
                end
            endcase
            bus.wr_ready = rdy;

            if (n == 1) begin
                check_output("exec_launch", 32'(bus.exec_requested), 32'(mask));
                check_output("launch_pc", bus.requested_pc, pc);
            end else begin
                check_output("exec_clear", 32'(bus.exec_requested), 32'd0);
            end

            if (bus.done) begin
                done_seen  = 1'b1;
                done_cycle = n;
                check_output("busy_at_done", 32'(bus.busy), 32'd0);
                check_output("pc_hold", bus.requested_pc, pc);
                if (start_at_done) begin
                    bus.core_mask = ~mask;
                    bus.start     = 1'b1;
                end
            end else begin
                check_output("busy_high", 32'(bus.busy), 32'd1);
                if (bus.wr_valid) begin
                    if (first_valid < 0) first_valid = n;
                    total++;
                    assert (nacc < exp_addr.size()) else begin
                        bad++;
                        $error("[TB] FAIL extra_write observed=%0d expected_below=%0d", nacc, exp_addr.size());
                    end
                    if (nacc < exp_addr.size()) begin
                        check_output("wr_addr", bus.wr_addr, exp_addr[nacc]);
                        check_output("wr_data", bus.wr_data, exp_data[nacc]);
                        if (rdy) nacc++;
                    end
                end
            end
        end

        total++;
        assert (done_seen) else begin
            bad++;
            $error("[TB] FAIL done_timeout observed=0 expected=1");
        end
        check_output("write_count", 32'(nacc), 32'(w));
        if (ready_mode == 0) begin
            exp_done = (mask == '0) ? 2 : ((w == 0) ? r_last + 2 : r_last + w * (L + 2) + 2);
            check_output("done_cycle", 32'(done_cycle), 32'(exp_done));
            if (w > 0) check_output("first_write_cycle", 32'(first_valid), 32'(r_last + L + 2));
        end
        tick();
        bus.start = 1'b0;
        check_output("done_pulse", 32'(bus.done), 32'd0);
        check_output("idle_after_done", 32'(bus.busy), 32'd0);
        check_output("no_relaunch", 32'(bus.exec_requested), 32'd0);
    endtask

    initial begin
        logic [N-1:0] m;
        logic [31:0]  gb, db;
        logic [15:0]  ln;

        salt            = $urandom;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.start_pc    = '0;
        bus.core_mask   = '0;
        bus.gather_base = '0;
        bus.gather_len  = '0;
        bus.dst_base    = '0;
        bus.ended       = '0;
        bus.wr_ready    = 1'b1;
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        $display("[TB] launch and gather, mask 0101 len 2");
        run_op(4'b0101, 32'h100, 32'h10, 16'd2, 32'h200, 0, 0, 1'b0);
        $display("[TB] backpressure on first write");
        run_op(4'b0101, 32'h104, 32'h10, 16'd2, 32'h200, 2, 0, 1'b0);
        $display("[TB] empty mask with start during busy and at done");
        run_op(4'b0000, 32'h300, 32'h20, 16'd3, 32'h400, 0, 1, 1'b1);
        $display("[TB] zero length");
        run_op(4'b1010, 32'h500, 32'h30, 16'd0, 32'h600, 0, 4, 1'b0);
        $display("[TB] address wrap");
        run_op(4'b0001, 32'h700, 32'hFFFF_FFFF, 16'd2, 32'hFFFF_FFFF, 0, 0, 1'b0);
        $display("[TB] all cores, random ready, restart while busy");
        run_op(4'b1111, 32'h800, 32'h40, 16'd3, 32'h900, 1, 12, 1'b1);

        $display("[TB] reset during write");
        apply_stimulus(4'b0011, 32'h40, 32'h80, 16'd3, 32'h300);
        bus.wr_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        for (int n = 0; n < 50 && !bus.wr_valid; n++) tick();
        total++;
        assert (bus.wr_valid) else begin
            bad++;
            $error("[TB] FAIL reach_write observed=0 expected=1");
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("midop_reset");
        tick();
        tick();
        check_output("post_reset_idle", 32'(bus.busy), 32'd0);
        check_output("post_reset_exec", 32'(bus.exec_requested), 32'd0);
        bus.wr_ready = 1'b1;

        $display("[TB] randomized operations");
        for (int it = 0; it < 16; it++) begin
            m  = N'($urandom_range(0, (1 << N) - 1));
            ln = 16'($urandom_range(0, 4));
            gb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            db = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
            run_op(m, $urandom, gb, ln, db, int'($urandom_range(0, 2)),
                   int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
